// File: rtl/line_debounce_pkg.sv
// Shared constants and helpers for the line debouncer.
package line_debounce_pkg;
  // Legal synchronizer depth; shallower is not metastability-safe, deeper only adds latency.
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Counter width able to hold 0..cycles without wrapping.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/line_debounce_bit.sv
// One conditioned line: synchronizer, polarity invert, debounce counter,
// edge pulses and a sticky event flag.
module line_debounce_bit
  import line_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_line,
  input  logic invert,
  input  logic event_clear,
  output logic line_out,
  output logic rise,
  output logic fall,
  output logic event_latched
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   line_q, line_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   ev_q, ev_d;
  logic                   sample;

  // Shift the raw line through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_line};
  end

  // Debounce: count consecutive differing samples, accept on the last one.
  // Edge pulses and event set are derived from the accept so they line up
  // with the first cycle lines_out shows the new value.
  always_comb begin
    sample = sync_q[SYNC_STAGES-1] ^ invert;
    line_d = line_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sample != line_q) begin
      if (cnt_q == CNT_LAST) begin
        line_d = sample;
        rise_d = sample;
        fall_d = ~sample;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Set wins over a coincident clear so no event is lost.
    if (rise_d || fall_d) ev_d = 1'b1;
    else if (event_clear) ev_d = 1'b0;
    else                  ev_d = ev_q;
  end

  // State registers; reset aborts any count in progress without a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      line_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      ev_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      line_q <= line_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      ev_q   <= ev_d;
    end
  end

  assign line_out      = line_q;
  assign rise          = rise_q;
  assign fall          = fall_q;
  assign event_latched = ev_q;
endmodule

// File: rtl/line_debounce.sv
// Debounces NUM_LINES asynchronous lines feeding line_matrix.
module line_debounce
  import line_debounce_pkg::*;
#(
  parameter int NUM_LINES       = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] raw_lines,
  input  logic [NUM_LINES-1:0] invert,
  input  logic [NUM_LINES-1:0] event_clear,
  output logic [NUM_LINES-1:0] lines_out,
  output logic [NUM_LINES-1:0] rise,
  output logic [NUM_LINES-1:0] fall,
  output logic [NUM_LINES-1:0] event_latched
);
  // Out-of-range depths are pulled into the legal window rather than building a broken chain.
  localparam int SYNC_EFF = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                            (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;

  // One independent debouncer per line.
  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    line_debounce_bit #(
      .SYNC_STAGES    (SYNC_EFF),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk          (clk),
      .rst          (rst),
      .raw_line     (raw_lines[i]),
      .invert       (invert[i]),
      .event_clear  (event_clear[i]),
      .line_out     (lines_out[i]),
      .rise         (rise[i]),
      .fall         (fall[i]),
      .event_latched(event_latched[i])
    );
  end
endmodule

// File: tb/tb_line_debounce.sv
// Directed bench for line_debounce (DEBOUNCE_CYCLES=4 main instance, =1 side instance).
module tb_line_debounce;
  logic       clk, rst;
  logic [7:0] raw_lines, invert, event_clear;
  logic [7:0] lines_out, rise, fall, event_latched;
  logic [1:0] raw1, lines1, rise1, fall1, ev1;
  int checks = 0;
  int errors = 0;

  line_debounce #(.NUM_LINES(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .raw_lines(raw_lines), .invert(invert),
    .event_clear(event_clear), .lines_out(lines_out), .rise(rise),
    .fall(fall), .event_latched(event_latched));

  line_debounce #(.NUM_LINES(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .raw_lines(raw1), .invert(2'b00),
    .event_clear(2'b00), .lines_out(lines1), .rise(rise1),
    .fall(fall1), .event_latched(ev1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; raw_lines = 8'h00; invert = 8'h00; event_clear = 8'h00; raw1 = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_lines", lines_out, 8'h00);
    chk("rst_rise", rise, 8'h00);
    chk("rst_ev", event_latched, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 4) begin
        chk("idle_lines", lines_out, 8'h00);
        chk("idle_edges", rise | fall, 8'h00);
        chk("idle_ev", event_latched, 8'h00);
      end
    end
  endtask

  task automatic test_rise;
    raw_lines = 8'h01;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("rise_early_lines", lines_out, 8'h00);
      chk("rise_early_pulse", rise, 8'h00);
    end
    @(negedge clk);
    chk("rise_lines", lines_out, 8'h01);
    chk("rise_pulse", rise, 8'h01);
    chk("rise_ev", event_latched, 8'h01);
    @(negedge clk);
    chk("rise_pulse_end", rise, 8'h00);
    chk("rise_hold", lines_out, 8'h01);
    chk("rise_ev_sticky", event_latched, 8'h01);
  endtask

  task automatic test_glitch;
    event_clear = 8'h01;
    @(negedge clk);
    event_clear = 8'h00;
    chk("clear_ev", event_latched, 8'h00);
    raw_lines = 8'h09;
    repeat (3) @(negedge clk);
    raw_lines = 8'h01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("glitch_lines", lines_out, 8'h01);
      chk("glitch_edges", rise | fall, 8'h00);
    end
    chk("glitch_ev", event_latched, 8'h00);
  endtask

  task automatic test_invert;
    invert = 8'h01;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("inv_early_lines", lines_out, 8'h01);
    end
    @(negedge clk);
    chk("inv_lines", lines_out, 8'h00);
    chk("inv_fall", fall, 8'h01);
    chk("inv_rise", rise, 8'h00);
    chk("inv_ev", event_latched, 8'h01);
    @(negedge clk);
    chk("inv_fall_end", fall, 8'h00);
  endtask

  task automatic test_event_clear;
    invert = 8'h00;
    repeat (3) @(negedge clk);
    event_clear = 8'h01;
    @(negedge clk);
    chk("evc_rise", rise, 8'h01);
    chk("evc_set_wins", event_latched, 8'h01);
    @(negedge clk);
    event_clear = 8'h00;
    chk("evc_cleared", event_latched, 8'h00);
    chk("evc_lines", lines_out, 8'h01);
  endtask

  task automatic test_reset_mid;
    raw_lines = 8'h21;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_lines", lines_out, 8'h00);
    chk("mid_rst_ev", event_latched, 8'h00);
    @(negedge clk);
    chk("mid_rst_edges", rise | fall, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("mid_early_lines", lines_out, 8'h00);
      chk("mid_early_rise", rise, 8'h00);
    end
    @(negedge clk);
    chk("mid_lines", lines_out, 8'h21);
    chk("mid_rise", rise, 8'h21);
    chk("mid_ev", event_latched, 8'h21);
  endtask

  task automatic test_dc1;
    raw1 = 2'b10;
    repeat (2) @(negedge clk);
    chk("dc1_early", {6'd0, lines1}, 8'h00);
    @(negedge clk);
    chk("dc1_lines", {6'd0, lines1}, 8'h02);
    chk("dc1_rise", {6'd0, rise1}, 8'h02);
    raw1 = 2'b00;
    repeat (3) @(negedge clk);
    chk("dc1_fall", {6'd0, fall1}, 8'h02);
    chk("dc1_lines_low", {6'd0, lines1}, 8'h00);
    chk("dc1_ev", {6'd0, ev1}, 8'h02);
  endtask

  initial begin
    test_reset;
    test_rise;
    test_glitch;
    test_invert;
    test_event_clear;
    test_reset_mid;
    test_dc1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_debounce.md
LINE_DEBOUNCE -- requirements
Module: line_debounce

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, number of lines conditioned; equals the line_matrix NUM_INPUTS it feeds.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per line; legal range 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required to accept a change; legal range 1..65535.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port raw_lines, input, NUM_LINES, asynchronous external lines.
REQ-007 SHALL have port invert, input, NUM_LINES, per-line polarity invert, synchronous to clk.
REQ-008 SHALL have port event_clear, input, NUM_LINES, per-line one-cycle clear of the sticky event flag.
REQ-009 SHALL have port lines_out, output, NUM_LINES, debounced lines that drive line_matrix input_lines.
REQ-010 SHALL have port rise, output, NUM_LINES, one-cycle pulse per line on an accepted 0->1 change.
REQ-011 SHALL have port fall, output, NUM_LINES, one-cycle pulse per line on an accepted 1->0 change.
REQ-012 SHALL have port event_latched, output, NUM_LINES, sticky flag per line set by any accepted change.

Function
REQ-013 SHALL pass each raw line through SYNC_STAGES flops; sync_q is the last stage's output.
REQ-014 SHALL form sample = sync_q XOR invert, combinationally, per line.
REQ-015 SHALL keep per line a counter of width clog2(DEBOUNCE_CYCLES+1), saturating, never wrapping.
REQ-016 SHALL clear the counter in every cycle where sample equals lines_out.
REQ-017 SHALL increment the counter in every cycle where sample differs from lines_out and the counter is below DEBOUNCE_CYCLES-1.
REQ-018 SHALL, when sample differs and the counter equals DEBOUNCE_CYCLES-1, load lines_out with sample and clear the counter on that edge.
REQ-019 SHALL, as a consequence, update lines_out exactly DEBOUNCE_CYCLES edges after sample changes, giving total latency SYNC_STAGES+DEBOUNCE_CYCLES edges from a raw edge.
REQ-020 SHALL treat a glitch shorter than DEBOUNCE_CYCLES cycles as no change: the counter returns to 0 and lines_out is unchanged.
REQ-021 SHALL, with DEBOUNCE_CYCLES=1, update lines_out one edge after sample changes.
REQ-022 SHALL register rise and fall high in exactly the cycle in which lines_out first shows the new value, for one cycle only.
REQ-023 SHALL treat a change of invert exactly like an input change, so it is debounced and produces rise or fall.
REQ-024 SHALL set event_latched[i] on rise[i] or fall[i]; event_clear[i] SHALL clear it on the next edge.
REQ-025 SHALL give set priority when set and event_clear coincide on the same edge, so the flag stays 1.
REQ-026 SHALL keep lines independent; simultaneous changes on several lines SHALL each follow REQ-016 to REQ-025.

Reset
REQ-027 SHALL, while rst is high, asynchronously force all synchronizer flops, counters, lines_out, rise, fall and event_latched to 0.
REQ-028 SHALL treat a raw line held at 1 (after invert) across deassertion as a normal change: rise pulses SYNC_STAGES+DEBOUNCE_CYCLES edges after the first post-reset edge.
REQ-029 SHALL abort any in-progress count on reset mid-operation with no pulse emitted.

Structure
REQ-030 SHALL place the SYNC_STAGES legal-range constants and the counter-width function in package line_debounce_pkg.
REQ-031 SHALL implement one line in sub-module line_debounce_bit, instantiated NUM_LINES times by generate.
REQ-032 SHALL mark synchronizer flops with the team's async-register attribute.

Verification
REQ-033 Reset with raw_lines=8'h00 -> after deassertion all outputs hold 0 indefinitely.
REQ-034 NUM_LINES=8, DEBOUNCE_CYCLES=4, raw_lines 8'h00->8'h01 held -> lines_out=8'h01 and rise=8'h01 for one cycle exactly 6 edges later; event_latched=8'h01.
REQ-035 Raw line 3 pulses high for 3 cycles (DEBOUNCE_CYCLES=4) -> lines_out, rise and event_latched remain 0.
REQ-036 lines_out=8'h01 steady, invert=8'h01 -> fall=8'h01 pulse and lines_out=8'h00 four edges after invert changes.
REQ-037 event_clear=8'h01 on the same edge as a new rise on line 0 -> event_latched[0] stays 1; event_clear alone on the next edge -> 0.
REQ-038 rst asserted at count 2 of 4 on line 5 -> no pulse; after release the line re-debounces from count 0.
